// File: rtl/cellrv32_clkgen.sv
// Purpose : central prescaler; turns peripheral enable requests into eight clk_i tick strobes (clk/2 .. clk/4096).
// Latency : request -> en_q after 1 edge, first count after 2 edges, first clk/2^n tick after 2+2^(n-1) edges.
// Backpress: none; freeze_i holds the prescaler in place and masks ticks, dropping all requests clears it.
module cellrv32_clkgen #(
    parameter int NUM_REQ = 8
) (
    input  logic               clk_i,
    input  logic               rstn_int_i,
    input  logic [NUM_REQ-1:0] clkgen_en_i,
    input  logic               freeze_i,
    output logic [7:0]         clkgen_o,
    output logic               active_o
);

    // IDLE: nobody asks for ticks, counter parked at zero.
    // RUN : counting, ticks generated from tap rising edges.
    // HOLD: requested but frozen; counter and its delayed copy stay put.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic         r_en_q;
    logic [11:0]  r_cnt;
    logic [11:0]  r_cnt_ff;
    logic [7:0]   r_tick;
    logic         r_active;

    logic         w_req_any;
    state_t       w_state;
    logic [11:0]  w_cnt_nxt;
    logic [11:0]  w_cnt_ff_nxt;
    logic [7:0]   w_tick_nxt;
    logic [7:0]   w_tap_now;
    logic [7:0]   w_tap_prev;

    assign w_req_any = |clkgen_en_i;

    // Tap bits feeding tick index 0..7; divide-by-2^n watches counter bit n-1.
    assign w_tap_now  = {r_cnt[11], r_cnt[10], r_cnt[9], r_cnt[6],
                         r_cnt[5], r_cnt[2], r_cnt[1], r_cnt[0]};
    assign w_tap_prev = {r_cnt_ff[11], r_cnt_ff[10], r_cnt_ff[9], r_cnt_ff[6],
                         r_cnt_ff[5], r_cnt_ff[2], r_cnt_ff[1], r_cnt_ff[0]};

    // Operating state is decoded from the registered request and the live freeze level,
    // so freeze takes effect on the very next edge.
    always_comb begin
        w_state = ST_IDLE;
        if (r_en_q) begin
            w_state = freeze_i ? ST_HOLD : ST_RUN;
        end
    end

    // Next counter, delayed counter and tick values for the current state.
    always_comb begin
        w_cnt_nxt    = 12'd0;
        w_cnt_ff_nxt = 12'd0;
        w_tick_nxt   = 8'd0;
        case (w_state)
            ST_RUN: begin
                // Wrap 4095 -> 0 only produces falling taps, hence no tick.
                w_cnt_nxt    = r_cnt + 12'd1;
                w_cnt_ff_nxt = r_cnt;
                w_tick_nxt   = w_tap_now & ~w_tap_prev;
            end
            ST_HOLD: begin
                // Holding both copies keeps the pending edge relationship intact,
                // so resuming neither loses nor repeats a tick.
                w_cnt_nxt    = r_cnt;
                w_cnt_ff_nxt = r_cnt_ff;
            end
            default: begin
                w_cnt_nxt    = 12'd0;
                w_cnt_ff_nxt = 12'd0;
            end
        endcase
    end

    // State registers: request sync, prescaler, tick strobes and running status.
    always_ff @(posedge clk_i or negedge rstn_int_i) begin
        if (!rstn_int_i) begin
            r_en_q   <= 1'b0;
            r_cnt    <= 12'd0;
            r_cnt_ff <= 12'd0;
            r_tick   <= 8'd0;
            r_active <= 1'b0;
        end else begin
            r_en_q   <= w_req_any;
            r_cnt    <= w_cnt_nxt;
            r_cnt_ff <= w_cnt_ff_nxt;
            r_tick   <= w_tick_nxt;
            r_active <= r_en_q & ~freeze_i;
        end
    end

    assign clkgen_o = r_tick;
    assign active_o = r_active;

endmodule

// File: tb/tb_cellrv32_clkgen.sv
// Scoreboard bench for cellrv32_clkgen: a cycle model pushes expected outputs,
// a monitor pops and compares them, and records tick times for directed checks
// against hand-computed first-tick latencies, periods and pulse counts.
module tb_cellrv32_clkgen;

    localparam int NUM_REQ = 8;

    logic               clk_i = 1'b0;
    logic               rstn_int_i = 1'b0;
    logic [NUM_REQ-1:0] clkgen_en_i = '0;
    logic               freeze_i = 1'b0;
    logic [7:0]         clkgen_o;
    logic               active_o;

    cellrv32_clkgen #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i       (clk_i),
        .rstn_int_i  (rstn_int_i),
        .clkgen_en_i (clkgen_en_i),
        .freeze_i    (freeze_i),
        .clkgen_o    (clkgen_o),
        .active_o    (active_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int kind;   // 0 first tick, 1 second tick, 2 last tick, 3 pulse count in window
        int bitn;
        int val;
    } dexp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mark = 0;
    int          win_lo = 0;
    int          win_hi = 0;
    logic [8:0]  exp_q[$];
    dexp_t       dq[$];
    int          div_log2 [8] = '{1, 2, 3, 6, 7, 10, 11, 12};

    // reference model state
    logic        m_en = 1'b0;
    int          m_cnt = 0;

    // monitor bookkeeping
    int          seen_mark = -1;
    int          first_k  [8];
    int          second_k [8];
    int          last_k   [8];
    int          pcount   [8];
    logic [7:0]  prev_tick = 8'h00;
    logic [8:0]  m_exp;
    logic [8:0]  m_got;
    int          m_k;
    dexp_t       m_d;
    int          m_meas;

    always @(posedge clk_i) cyc <= cyc + 1;

    // A clk/2^n tick follows an edge where the pre-edge count is an odd multiple of 2^(n-1).
    function automatic logic [7:0] ticks_of(input int c);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int p;
            p = 1 << div_log2[i];
            r[i] = ((c % p) == (p / 2));
        end
        return r;
    endfunction

    // Cycle model: predicts the outputs visible after each rising edge.
    always @(posedge clk_i) begin
        if (!rstn_int_i) begin
            exp_q.push_back(9'h000);
            m_en  <= 1'b0;
            m_cnt <= 0;
        end else begin
            exp_q.push_back({m_en & ~freeze_i, (m_en & ~freeze_i) ? ticks_of(m_cnt) : 8'h00});
            if (!m_en)
                m_cnt <= 0;
            else if (!freeze_i)
                m_cnt <= (m_cnt + 1) % 4096;
            m_en <= |clkgen_en_i;
        end
    end

    // Monitor: compares every cycle, watches for async reset, records tick times.
    initial begin
        #1;
        forever begin
            @(negedge clk_i or negedge rstn_int_i);
            if (clk_i) begin
                #1;
                checks++;
                if ({active_o, clkgen_o} !== 9'h000) begin
                    errors++;
                    $display("FAIL async_rst: got active=%b ticks=%b, want all 0", active_o, clkgen_o);
                end
            end else begin
                m_got = {active_o, clkgen_o};
                if (mark != seen_mark) begin
                    seen_mark = mark;
                    for (int i = 0; i < 8; i++) begin
                        first_k[i]  = -1;
                        second_k[i] = -1;
                        last_k[i]   = -1;
                        pcount[i]   = 0;
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: no expected entry at cycle %0d, got %h", cyc, m_got);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (!rstn_int_i) m_exp = 9'h000;
                    if (m_got !== m_exp) begin
                        errors++;
                        $display("FAIL sb_cycle %0d: got active=%b ticks=%b, want active=%b ticks=%b",
                                 cyc, m_got[8], m_got[7:0], m_exp[8], m_exp[7:0]);
                    end
                end
                for (int i = 1; i < 8; i++) begin
                    if (m_got[i]) begin
                        checks++;
                        if (prev_tick[i]) begin
                            errors++;
                            $display("FAIL single_cycle bit%0d at cycle %0d: got 2 adjacent, want 1", i, cyc);
                        end
                    end
                end
                m_k = cyc - mark;
                for (int i = 0; i < 8; i++) begin
                    if (m_got[i]) begin
                        if (first_k[i] < 0) first_k[i] = m_k;
                        else if (second_k[i] < 0) second_k[i] = m_k;
                        last_k[i] = m_k;
                        if (m_k >= win_lo && m_k < win_hi) pcount[i]++;
                    end
                end
                prev_tick = m_got[7:0];
                while (dq.size() > 0) begin
                    m_d = dq.pop_front();
                    case (m_d.kind)
                        0:       m_meas = first_k[m_d.bitn];
                        1:       m_meas = second_k[m_d.bitn];
                        2:       m_meas = last_k[m_d.bitn];
                        default: m_meas = pcount[m_d.bitn];
                    endcase
                    checks++;
                    if (m_meas != m_d.val) begin
                        errors++;
                        $display("FAIL dir_kind%0d bit%0d: got %0d, want %0d", m_d.kind, m_d.bitn, m_meas, m_d.val);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic new_scn(input int lo, input int hi);
        mark   = cyc;
        win_lo = lo;
        win_hi = hi;
    endtask

    task automatic expect_d(input int kind, input int b, input int v);
        dexp_t d;
        d.kind = kind;
        d.bitn = b;
        d.val  = v;
        dq.push_back(d);
    endtask

    initial begin
        int first_tab [8];
        int cnt_tab   [8];
        first_tab = '{3, 4, 6, 34, 66, 514, 1026, 2050};
        cnt_tab   = '{6144, 3072, 1536, 192, 96, 12, 6, 3};

        // reset, then idle
        step(3);
        rstn_int_i = 1'b1;
        step(3);

        // long single request: first-tick latencies and 3x4096 pulse counts
        new_scn(3, 3 + 3 * 4096);
        clkgen_en_i[3] = 1'b1;
        step(12300);
        for (int i = 0; i < 8; i++) begin
            expect_d(0, i, first_tab[i]);
            expect_d(3, i, cnt_tab[i]);
        end
        expect_d(1, 7, 6146);
        step(2);

        // request drop: nothing from the second edge after the drop
        new_scn(2, 100);
        clkgen_en_i = '0;
        step(60);
        expect_d(3, 0, 0);
        expect_d(3, 7, 0);
        step(2);

        // overlapping requesters: req0 0..100, req5 50..300
        new_scn(0, 100000);
        clkgen_en_i[0] = 1'b1;
        step(50);
        clkgen_en_i[5] = 1'b1;
        step(50);
        clkgen_en_i[0] = 1'b0;
        step(200);
        clkgen_en_i[5] = 1'b0;
        step(20);
        expect_d(3, 0, 150);
        expect_d(2, 0, 301);
        expect_d(3, 3, 5);
        expect_d(3, 4, 2);
        expect_d(1, 4, 194);
        expect_d(3, 5, 0);
        step(2);

        // freeze for 37 cycles once cnt reaches 1000
        new_scn(1002, 1039);
        clkgen_en_i[2] = 1'b1;
        step(1001);
        freeze_i = 1'b1;
        step(37);
        freeze_i = 1'b0;
        step(1100);
        expect_d(3, 0, 0);
        expect_d(0, 5, 514);
        expect_d(1, 5, 1575);
        expect_d(0, 6, 1063);
        expect_d(0, 7, 2087);
        step(2);
        clkgen_en_i = '0;
        step(5);

        // async reset with cnt at 3000 and a clk/2 tick in flight
        new_scn(0, 100000);
        clkgen_en_i[7] = 1'b1;
        step(3001);
        #1;
        rstn_int_i = 1'b0;
        step(2);
        rstn_int_i = 1'b1;
        new_scn(0, 100000);
        step(100);
        for (int i = 0; i < 5; i++) expect_d(0, i, first_tab[i]);
        step(2);
        clkgen_en_i = '0;
        step(5);

        // freeze with no requests, then a request while frozen
        freeze_i = 1'b1;
        step(20);
        new_scn(0, 100000);
        clkgen_en_i[1] = 1'b1;
        step(20);
        freeze_i = 1'b0;
        step(100);
        expect_d(0, 0, 22);
        expect_d(0, 1, 23);
        expect_d(0, 2, 25);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
